// File: rtl/network_spike_io.sv
// Host spike I/O: input FIFO feeding a four-phase event injector, output spike FIFO.
// Ports: host wr_*/out_*, processor input_*/output_*, status in_count/timeout_err/drop_count.
module network_spike_io #(
  parameter int SR_DEPTH    = 16384,
  parameter int NR_DEPTH    = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 256,
  localparam int IW = $clog2(SR_DEPTH),
  localparam int OW = $clog2(NR_DEPTH),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [IW-1:0] wr_index,
  output logic          wr_ready,
  output logic          input_occurred,
  output logic [IW-1:0] input_index,
  input  logic          input_ack,
  input  logic          output_occurred,
  input  logic [OW-1:0] output_index,
  output logic          out_valid,
  output logic [OW-1:0] out_index,
  input  logic          out_ready,
  output logic [CW-1:0] in_count,
  output logic          timeout_err,
  output logic [7:0]    drop_count,
  input  logic          err_clear
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_e;

  state_e          state_q, state_d;
  logic            occ_q, occ_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            terr_q, terr_d;
  logic [7:0]      drop_q, drop_d;
  logic [PW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [PW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [IW-1:0]   in_mem_q  [FIFO_DEPTH];
  logic [OW-1:0]   out_mem_q [FIFO_DEPTH];

  logic in_push, in_pop;
  logic out_push, out_pop, out_drop;

  assign wr_ready       = in_cnt_q != FULL;
  assign in_push        = wr_valid && wr_ready;
  assign in_count       = in_cnt_q;
  assign input_occurred = occ_q;
  assign input_index    = idx_q;
  assign timeout_err    = terr_q;
  assign drop_count     = drop_q;

  assign out_valid = out_cnt_q != '0;
  assign out_pop   = out_valid && out_ready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign out_push  = output_occurred && (out_cnt_q != FULL || out_pop);
  assign out_drop  = output_occurred && !out_push;
  // Stale storage is hidden while empty so the port reads 0 out of reset.
  assign out_index = out_valid ? out_mem_q[out_rd_q] : '0;

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    in_pop  = 1'b0;
    terr_d  = err_clear ? 1'b0 : terr_q;
    unique case (state_q)
      IDLE: begin
        if (in_cnt_q != '0) begin
          state_d = REQ;
          occ_d   = 1'b1;
          idx_d   = in_mem_q[in_rd_q];
        end
      end
      REQ: begin
        if (input_ack) begin
          in_pop  = 1'b1;
          occ_d   = 1'b0;
          state_d = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          in_pop  = 1'b1;
          occ_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!input_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_wr_d  = in_push ? in_wr_q + 1'b1 : in_wr_q;
    in_rd_d  = in_pop ? in_rd_q + 1'b1 : in_rd_q;
    in_cnt_d = in_cnt_q;
    unique case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase
    out_wr_d  = out_push ? out_wr_q + 1'b1 : out_wr_q;
    out_rd_d  = out_pop ? out_rd_q + 1'b1 : out_rd_q;
    out_cnt_d = out_cnt_q;
    unique case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (out_drop) begin
      if (err_clear)          drop_d = 8'd1;
      else if (drop_q != '1)  drop_d = drop_q + 8'd1;
    end else if (err_clear) begin
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      occ_q     <= 1'b0;
      idx_q     <= '0;
      tmo_q     <= '0;
      terr_q    <= 1'b0;
      drop_q    <= '0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      terr_q    <= terr_d;
      drop_q    <= drop_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= wr_index;
    if (out_push) out_mem_q[out_wr_q] <= output_index;
  end

endmodule

// File: tb/tb_network_spike_io.sv
// Randomized bench for network_spike_io against a queue-based reference model.
// Phases: mixed traffic, ack starvation, output overflow, reset mid-request.
module tb_network_spike_io;
  localparam int DEPTH = 16;
  localparam int TMO   = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [13:0] wr_index = '0;
  logic        wr_ready;
  logic        input_occurred;
  logic [13:0] input_index;
  logic        input_ack = 1'b0;
  logic        output_occurred = 1'b0;
  logic [3:0]  output_index = '0;
  logic        out_valid;
  logic [3:0]  out_index;
  logic        out_ready = 1'b0;
  logic [4:0]  in_count;
  logic        timeout_err;
  logic [7:0]  drop_count;
  logic        err_clear = 1'b0;

  always #5 clk = ~clk;

  network_spike_io dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_ready(wr_ready),
    .input_occurred(input_occurred), .input_index(input_index),
    .input_ack(input_ack),
    .output_occurred(output_occurred), .output_index(output_index),
    .out_valid(out_valid), .out_index(out_index), .out_ready(out_ready),
    .in_count(in_count), .timeout_err(timeout_err),
    .drop_count(drop_count), .err_clear(err_clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference model: pending events, outstanding request, spike queue.
  int inq[$];
  int outq[$];
  bit m_req, m_rel;
  int m_age, m_idx, m_terr, m_drops;

  int p_wr, p_ack, p_oo, p_rdy, p_clr;

  task automatic model_reset();
    inq.delete();
    outq.delete();
    m_req = 0; m_rel = 0;
    m_age = 0; m_idx = 0;
    m_terr = 0; m_drops = 0;
  endtask

  task automatic compare();
    chk("occ", input_occurred, m_req);
    chk("idx", input_index, m_idx);
    chk("wr_ready", wr_ready, inq.size() != DEPTH);
    chk("in_count", in_count, inq.size());
    chk("out_valid", out_valid, outq.size() != 0);
    if (outq.size() != 0) chk("out_index", out_index, outq[0]);
    chk("timeout_err", timeout_err, m_terr);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic step();
    bit push, pop, tset, opop, acc, drop;
    wr_valid        = $urandom_range(99) < p_wr;
    wr_index        = 14'($urandom_range(16383));
    input_ack       = $urandom_range(99) < p_ack;
    output_occurred = $urandom_range(99) < p_oo;
    output_index    = 4'($urandom_range(15));
    out_ready       = $urandom_range(99) < p_rdy;
    err_clear       = $urandom_range(99) < p_clr;

    push = wr_valid && inq.size() < DEPTH;
    pop  = 0;
    tset = 0;
    if (m_req) begin
      if (input_ack) begin
        pop = 1; m_req = 0; m_rel = 1;
      end else if (m_age == TMO - 1) begin
        pop = 1; tset = 1; m_req = 0; m_rel = 1;
      end else begin
        m_age++;
      end
    end else if (m_rel) begin
      if (!input_ack) m_rel = 0;
    end else if (inq.size() != 0) begin
      m_req = 1; m_age = 0; m_idx = inq[0];
    end
    if (pop)  void'(inq.pop_front());
    if (push) inq.push_back(int'(wr_index));

    opop = outq.size() != 0 && out_ready;
    acc  = output_occurred && (outq.size() < DEPTH || opop);
    drop = output_occurred && !acc;
    if (opop) void'(outq.pop_front());
    if (acc)  outq.push_back(int'(output_index));

    if (tset)           m_terr = 1;
    else if (err_clear) m_terr = 0;
    if (drop)           m_drops = err_clear ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
    else if (err_clear) m_drops = 0;

    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic knobs(input int wr, input int ack, input int oo,
                       input int rdy, input int clr);
    p_wr = wr; p_ack = ack; p_oo = oo; p_rdy = rdy; p_clr = clr;
  endtask

  task automatic quiet();
    wr_valid = 0; input_ack = 0; output_occurred = 0;
    out_ready = 0; err_clear = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_occ"}, input_occurred, 0);
    chk({tag, "_idx"}, input_index, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_in_count"}, in_count, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_drops"}, drop_count, 0);
  endtask

  initial begin
    model_reset();
    quiet();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    knobs(40, 50, 30, 40, 3);
    repeat (3000) step();

    knobs(50, 0, 0, 50, 0);
    repeat (800) step();
    chk("terr_set", timeout_err, 1);
    knobs(0, 0, 0, 50, 100);
    step();
    knobs(0, 0, 0, 50, 0);
    step();

    knobs(0, 50, 100, 0, 0);
    repeat (320) step();
    chk("drop_sat", drop_count, 255);
    knobs(0, 50, 100, 100, 0);
    repeat (3) step();
    knobs(0, 50, 0, 0, 100);
    step();

    knobs(60, 80, 50, 60, 2);
    repeat (1000) step();

    knobs(0, 50, 0, 100, 0);
    repeat (600) step();
    knobs(100, 0, 0, 0, 0);
    repeat (4) step();
    knobs(0, 0, 0, 0, 0);
    repeat (2) step();
    chk("pre_rst_req", input_occurred, 1);
    quiet();
    reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    compare();

    knobs(30, 50, 30, 50, 2);
    repeat (600) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
